// File: rtl/cam_pkg.sv
// Shared types, frame geometry and the RGB565 -> RGB444 packing helper
// for the OV7670-style capture path.
package cam_pkg;

    localparam int unsigned IMG_W    = 160;
    localparam int unsigned IMG_H    = 120;
    localparam int unsigned FB_DEPTH = IMG_W * IMG_H;
    localparam int unsigned PX_W     = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VSYNC   = 2'd1,
        BYTE_HI = 2'd2,
        BYTE_LO = 2'd3
    } cam_state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Keep the top nibble of each RGB565 channel.
    function automatic rgb444_t rgb565_to_rgb444(input logic [7:0] hi, input logic [7:0] lo);
        rgb444_t px;
        px.r = hi[7:4];
        px.g = {hi[2:0], lo[7]};
        px.b = lo[4:1];
        return px;
    endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Pixel packer plus output register stage: one cycle after the low byte
// is sampled it presents the write strobe, address and packed pixel.
module cam_px_pack
    import cam_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        hi_i,
    input  logic [7:0]        lo_i,
    output logic [ADDR_W-1:0] px_addr_o,
    output logic [PX_W-1:0]   px_data_o,
    output logic              px_wr_o
);

    logic [ADDR_W-1:0] px_addr_q;
    rgb444_t           px_data_q;
    logic              px_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            px_addr_q <= '0;
            px_data_q <= '0;
            px_wr_q   <= 1'b0;
        end else begin
            px_wr_q <= wr_en_i;
            if (wr_en_i) begin
                px_addr_q <= addr_i;
                px_data_q <= rgb565_to_rgb444(hi_i, lo_i);
            end
        end
    end

    assign px_addr_o = px_addr_q;
    assign px_data_o = PX_W'(px_data_q);
    assign px_wr_o   = px_wr_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670-style capture: byte-pair FSM, frame-buffer address counter and overflow.
// Optional per-frame line statistics are enabled with CAM_CAPTURE_STATS_EN.
module cam_capture_rgb444 #(
    parameter int unsigned IMG_W  = cam_pkg::IMG_W,
    parameter int unsigned IMG_H  = cam_pkg::IMG_H,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CAM_vsync,
    input  logic              CAM_href,
    input  logic [7:0]        CAM_px_data,
    output logic [ADDR_W-1:0] mem_px_addr,
    output logic [11:0]       mem_px_data,
    output logic              px_wr,
    output logic              frame_done,
    output logic              overflow
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [7:0]        line_cnt,
    output logic              line_err
`endif
);
    import cam_pkg::*;

    localparam int unsigned FRAME_PIX  = IMG_W * IMG_H;
    localparam int unsigned LINE_BYTES = 2 * IMG_W;

    cam_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        hi_q;
    logic              frame_done_q;
    logic              overflow_q;
    logic              wr_en_c;
    logic              frame_start_c;

    // A write is issued only while the frame buffer still has room.
    assign wr_en_c = (state_q == BYTE_LO) && !CAM_vsync && CAM_href &&
                     (addr_q != ADDR_W'(FRAME_PIX));
    assign frame_start_c = (state_q == VSYNC) && !CAM_vsync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            hi_q         <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (CAM_vsync) state_q <= VSYNC;
                end
                VSYNC: begin
                    if (!CAM_vsync) begin
                        addr_q     <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= BYTE_HI;
                    end
                end
                BYTE_HI: begin
                    if (CAM_vsync) begin
                        frame_done_q <= 1'b1;
                        state_q      <= VSYNC;
                    end else if (CAM_href) begin
                        hi_q    <= CAM_px_data;
                        state_q <= BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (CAM_vsync) begin
                        frame_done_q <= 1'b1;
                        hi_q         <= '0;
                        state_q      <= VSYNC;
                    end else if (CAM_href) begin
                        if (wr_en_c) addr_q <= addr_q + ADDR_W'(1);
                        else         overflow_q <= 1'b1;
                        state_q <= BYTE_HI;
                    end else begin
                        // Odd byte count: drop the stray high byte so the next line is aligned.
                        hi_q    <= '0;
                        state_q <= BYTE_HI;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cam_px_pack #(.ADDR_W(ADDR_W)) u_pack (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_c),
        .addr_i    (addr_q),
        .hi_i      (hi_q),
        .lo_i      (CAM_px_data),
        .px_addr_o (mem_px_addr),
        .px_data_o (mem_px_data),
        .px_wr_o   (px_wr)
    );

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef CAM_CAPTURE_STATS_EN
    logic       href_q;
    logic [9:0] bytes_q;
    logic [7:0] lines_q;
    logic [7:0] line_cnt_q;
    logic       line_err_q;
    logic       capture_c;
    logic       href_fall_c;

    assign capture_c   = (state_q == BYTE_HI) || (state_q == BYTE_LO);
    assign href_fall_c = capture_c && href_q && !CAM_href;

    always_ff @(posedge clk) begin
        if (rst) begin
            href_q     <= 1'b0;
            bytes_q    <= '0;
            lines_q    <= '0;
            line_cnt_q <= '0;
            line_err_q <= 1'b0;
        end else begin
            href_q <= CAM_href;
            if (frame_start_c) begin
                bytes_q    <= '0;
                lines_q    <= '0;
                line_cnt_q <= '0;
                line_err_q <= 1'b0;
            end else if (capture_c) begin
                if (CAM_vsync) begin
                    line_cnt_q <= lines_q + 8'(href_fall_c);
                end else begin
                    if (CAM_href && (bytes_q != '1)) bytes_q <= bytes_q + 10'd1;
                    if (href_fall_c) begin
                        lines_q <= lines_q + 8'd1;
                        bytes_q <= '0;
                        if (bytes_q != 10'(LINE_BYTES)) line_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign line_cnt = line_cnt_q;
    assign line_err = line_err_q;
`endif

endmodule
